// File: rtl/baccarat_round_ctrl.sv
// baccarat_round_ctrl: timed deal sequencer with third-card rules and win lights; tallies under BACCARAT_ROUND_TALLY_EN
module baccarat_round_ctrl #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int TALLY_W = 8
) (
  input  logic               fast_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               busy,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic [TALLY_W-1:0] rounds,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);
  localparam int CW = $clog2(STEP_CYCLES);
  typedef enum logic [3:0] {IDLE, P1, D1, P2, D2, CHK, P3, CHK3, D3, RESULT} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic deal, done, draw, enter_res, entry;
  assign deal = state inside {P1, D1, P2, D2, P3, D3};
  assign done = cnt == CW'(STEP_CYCLES - 1);
  assign enter_res = next == RESULT && state != RESULT;
  assign draw = dscore <= 4'd2
    || (dscore == 4'd3 && pcard3 != 4'd8)
    || (dscore == 4'd4 && pcard3 >= 4'd2 && pcard3 <= 4'd7)
    || (dscore == 4'd5 && pcard3 >= 4'd4 && pcard3 <= 4'd7)
    || (dscore == 4'd6 && pcard3 >= 4'd6 && pcard3 <= 4'd7);
  always_ff @(posedge fast_clock) begin
    if (!resetb) begin
      state <= IDLE;
      cnt <= '0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else begin
      state <= next;
      cnt <= (deal && !done) ? cnt + 1'b1 : '0;
      if (enter_res) begin
        player_win_light <= pscore >= dscore;
        dealer_win_light <= dscore >= pscore;
      end else if (state == RESULT && next != RESULT) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
      end
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE, RESULT: next = start ? P1 : state;
      P1:   next = done ? D1 : P1;
      D1:   next = done ? P2 : D1;
      P2:   next = done ? D2 : P2;
      D2:   next = done ? CHK : D2;
      CHK:  next = (pscore >= 4'd8 || dscore >= 4'd8) ? RESULT :
                   pscore <= 4'd5 ? P3 : dscore <= 4'd5 ? D3 : RESULT;
      P3:   next = done ? CHK3 : P3;
      CHK3: next = draw ? D3 : RESULT;
      D3:   next = done ? RESULT : D3;
      default: next = IDLE;
    endcase
  end
  // strobes are gated by reset so none escapes during the reset cycle
  always_comb begin
    entry = resetb && cnt == '0;
    load_pcard1 = entry && state == P1;
    load_dcard1 = entry && state == D1;
    load_pcard2 = entry && state == P2;
    load_dcard2 = entry && state == D2;
    load_pcard3 = entry && state == P3;
    load_dcard3 = entry && state == D3;
    busy = state != IDLE && state != RESULT;
  end
`ifdef BACCARAT_ROUND_TALLY_EN
  always_ff @(posedge fast_clock) begin
    if (!resetb) begin
      rounds <= '0;
      player_wins <= '0;
      dealer_wins <= '0;
      ties <= '0;
    end else if (enter_res) begin
      rounds <= rounds + TALLY_W'(rounds != '1);
      player_wins <= player_wins + TALLY_W'(pscore > dscore && player_wins != '1);
      dealer_wins <= dealer_wins + TALLY_W'(dscore > pscore && dealer_wins != '1);
      ties <= ties + TALLY_W'(pscore == dscore && ties != '1);
    end
  end
`else
  assign rounds = '0;
  assign player_wins = '0;
  assign dealer_wins = '0;
  assign ties = '0;
`endif
endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// tb_baccarat_round_ctrl: randomized rounds checked by a scoreboard against a baccarat rule model
module tb_baccarat_round_ctrl;
  localparam int S = 4;
  localparam int TW = 3;
  logic clk = 1'b0, resetb = 1'b0, start = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic lp1, lp2, lp3, ld1, ld2, ld3, busy, plw, dlw;
  logic [TW-1:0] rounds, pwins, dwins, ties;
  typedef struct {
    bit plw, dlw;
    int len, p3_at, d3_at, nstr;
    logic [TW-1:0] r, pw, dw, t;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [TW-1:0] mr = '0, mpw = '0, mdw = '0, mt = '0;
  baccarat_round_ctrl #(.STEP_CYCLES(S), .TALLY_W(TW)) dut (
    .fast_clock(clk), .resetb(resetb), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .busy(busy), .player_win_light(plw), .dealer_win_light(dlw),
    .rounds(rounds), .player_wins(pwins), .dealer_wins(dwins), .ties(ties)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // pcard3 values on which the dealer draws, indexed by dealer two-card score
  function automatic bit dealer_draws(int d, int c);
    int mask[8] = '{32'h3FFF, 32'h3FFF, 32'h3FFF, 32'h3EFF, 32'h00FC, 32'h00F0, 32'h00C0, 32'h0000};
    int m;
    m = mask[d];
    return m[c];
  endfunction
  function automatic logic [TW-1:0] sat(logic [TW-1:0] v, bit inc);
    return (inc && v != '1) ? v + 1'b1 : v;
  endfunction
  initial begin
    int cyc = 0, t0 = 0, p3_at = -1, d3_at = -1, nstr = 0;
    bit pbusy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetb) begin
        pbusy = 0;
        nstr = 0;
      end else begin
        if (lp1) begin
          t0 = cyc; p3_at = -1; d3_at = -1; nstr = 0;
          chk("lights_clear_at_p1", {plw, dlw}, 0);
        end
        nstr += int'(lp1) + int'(lp2) + int'(lp3) + int'(ld1) + int'(ld2) + int'(ld3);
        if (ld2) chk("d2_strobe_time", cyc - t0, 3 * S);
        if (lp3) p3_at = cyc - t0;
        if (ld3) d3_at = cyc - t0;
        if (pbusy && !busy && (plw || dlw)) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk("player_light", plw, e.plw);
            chk("dealer_light", dlw, e.dlw);
            chk("result_time", cyc - t0, e.len);
            chk("pcard3_strobe", p3_at, e.p3_at);
            chk("dcard3_strobe", d3_at, e.d3_at);
            chk("strobe_count", nstr, e.nstr);
            chk("rounds", rounds, e.r);
            chk("player_wins", pwins, e.pw);
            chk("dealer_wins", dwins, e.dw);
            chk("ties", ties, e.t);
          end
        end
        pbusy = busy;
      end
    end
  end
  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask
  task automatic round(input int p2, d2, pc, pf, df, output int waited);
    exp_t e;
    bit nat, pd, dd;
    int fp, fd, n;
    nat = p2 >= 8 || d2 >= 8;
    pd = !nat && p2 <= 5;
    dd = !nat && (pd ? dealer_draws(d2, pc) : d2 <= 5);
    fp = pd ? pf : p2;
    fd = dd ? df : d2;
    e.plw = fp >= fd;
    e.dlw = fd >= fp;
    e.len = 4 * S + 1 + (pd ? S + 1 : 0) + (dd ? S : 0);
    e.p3_at = pd ? 4 * S + 1 : -1;
    e.d3_at = dd ? (pd ? 5 * S + 2 : 4 * S + 1) : -1;
    e.nstr = 4 + int'(pd) + int'(dd);
`ifdef BACCARAT_ROUND_TALLY_EN
    mr = sat(mr, 1);
    mpw = sat(mpw, fp > fd);
    mdw = sat(mdw, fd > fp);
    mt = sat(mt, fp == fd);
`endif
    e.r = mr; e.pw = mpw; e.dw = mdw; e.t = mt;
    q.push_back(e);
    pscore = 4'(p2); dscore = 4'(d2); pcard3 = 4'(pc);
    start = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!lp1 && waited < 10);
    if (!lp1) begin
      chk("p1_start_timeout", 0, 1);
      finish_now();
    end
    start = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (lp3) pscore = 4'(pf);
      if (ld3) dscore = 4'(df);
    end while (busy && n < 60);
    if (busy) begin
      chk("round_timeout", 0, 1);
      finish_now();
    end
  endtask
  initial begin
    int w;
    int dir[4][5] = '{'{8, 3, 0, 0, 0}, '{4, 6, 7, 1, 9}, '{4, 6, 5, 0, 0}, '{6, 5, 0, 0, 6}};
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_lights", {plw, dlw}, 0);
    chk("reset_strobes", {lp1, lp2, lp3, ld1, ld2, ld3}, 0);
    chk("reset_tallies", {rounds, pwins, dwins, ties}, 0);
    resetb = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) round(dir[i][0], dir[i][1], dir[i][2], dir[i][3], dir[i][4], w);
    start = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!ld1 && w < 4 * S);
    chk("reach_d1", ld1, 1);
    resetb = 1'b0;
    start = 1'b0;
    #1 chk("no_strobe_in_reset", ld1, 0);
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_lights", {plw, dlw}, 0);
    chk("post_reset_strobes", {lp1, lp2, lp3, ld1, ld2, ld3}, 0);
    chk("post_reset_tallies", {rounds, pwins, dwins, ties}, 0);
    mr = '0; mpw = '0; mdw = '0; mt = '0;
    resetb = 1'b1;
    round(9, 2, 0, 0, 0, w);
    chk("p1_latency_from_idle", w, 1);
    for (int i = 0; i < 40; i++)
      round($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13),
            $urandom_range(0, 9), $urandom_range(0, 9), w);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    finish_now();
  end
endmodule

// File: doc/baccarat_round_ctrl.md
# baccarat_round_ctrl

Autonomous round controller for the baccarat datapath. It replaces the manual KEY[0] stepping with a timed sequencer on `fast_clock`. It issues the six card-load strobes in dealing order, applies the third-card drawing rules to `pscore`/`dscore`/`pcard3` from the datapath, and drives the win lights. Optional win/round tally counters feed the HEX/LEDR display logic.

## Interface
- `STEP_CYCLES`, default 25_000_000: dwell in each deal state in clock cycles (0.5 s at 50 MHz); legal range ≥ 2.
- `TALLY_W`, default 8: width of each tally counter.

- `fast_clock`  in  1  sole clock; all state changes on its rising edge.
- `resetb`  in  1  reset, synchronous and active-low.
- `start`  in  1  level; sampled in IDLE and RESULT; high begins a round.
- `pscore`  in  4  player score from datapath, 0–9.
- `dscore`  in  4  dealer score from datapath, 0–9.
- `pcard3`  in  4  player third card value from datapath, 0–13.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  one-cycle capture enables to datapath.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  one-cycle capture enables to datapath.
- `busy`  out  1  high in every state except IDLE and RESULT.
- `player_win_light`, `dealer_win_light`  out  1 each  round outcome; both high on a tie.
- `rounds`, `player_wins`, `dealer_wins`, `ties`  out  `TALLY_W` each  tally counters.

## Operation
- States: IDLE, P1, D1, P2, D2, CHK, P3, CHK3, D3, RESULT.
- IDLE/RESULT with `start`=1: go to P1. On leaving RESULT, clear both lights.
- Deal states (P1, D1, P2, D2, P3, D3):
  - The matching `load_*` strobe is high on the entry cycle only.
  - The state dwells `STEP_CYCLES` cycles.
  - Order is P1 → D1 → P2 → D2 → CHK.
- CHK, one cycle, first matching rule wins:
  - `pscore` ≥ 8 or `dscore` ≥ 8 → RESULT (natural).
  - `pscore` ≤ 5 → P3.
  - `dscore` ≤ 5 → D3.
  - Otherwise → RESULT.
- P3 → CHK3 (one cycle). CHK3 goes to D3 if the dealer draws, else RESULT. The dealer draws when:
  - `dscore` ≤ 2: always.
  - `dscore` = 3: `pcard3` ≠ 8.
  - `dscore` = 4: `pcard3` in 2..7.
  - `dscore` = 5: `pcard3` in 4..7.
  - `dscore` = 6: `pcard3` in 6..7.
  - `dscore` = 7: never.
- D3 → RESULT.
- RESULT entry cycle:
  - `player_win_light` = (`pscore` > `dscore`) or tie.
  - `dealer_win_light` = (`dscore` > `pscore`) or tie.
  - Lights are held until the state leaves RESULT.
- Tallies, updated on the RESULT entry cycle:
  - `rounds` +1.
  - Exactly one of `player_wins` / `dealer_wins` / `ties` +1.
  - Each counter saturates at all-ones; no wrap.
- `start` is ignored while `busy`.
- `start` held high runs rounds back-to-back, with one RESULT cycle between rounds.

## Timing
- Reset values: state IDLE, all `load_*` 0, `busy` 0, both lights 0, all tallies 0, dwell counter 0.
- Reset mid-round: the next cycle is in IDLE, no strobe is emitted on or after the reset cycle, and tallies are cleared.
- `start` high in IDLE at cycle t → P1 entered and `load_pcard1` high at t+1.
- Let T = entry cycle of P1 and S = `STEP_CYCLES`:
  - Strobes occur at T, T+S, T+2S, T+3S.
  - CHK is at T+4S.
  - Natural or both stand: RESULT at T+4S+1.
  - Player stands, dealer draws: D3 strobe at T+4S+1; RESULT at T+5S+1.
  - Player draws, dealer stands: P3 strobe at T+4S+1; CHK3 at T+5S+1; RESULT at T+5S+2.
  - Both draw: D3 strobe at T+5S+2; RESULT at T+6S+2.
- Datapath scores are registered one cycle after a strobe, so they are stable at CHK/CHK3/RESULT for any S ≥ 2.
- Lights and tallies change on the RESULT entry edge and are visible the following cycle.

## Configuration
- `BACCARAT_ROUND_TALLY_EN` defined: the four tally counters and their saturation logic are compiled in.
- Not defined: `rounds`, `player_wins`, `dealer_wins` and `ties` are tied to 0 and no counter registers exist. Sequencing and lights are unchanged.

## Test plan
All scenarios use `STEP_CYCLES`=4, TALLY_W=8, macro defined unless stated; T = P1 entry.
- Natural: after D2 set `pscore`=8, `dscore`=3 → no `load_pcard3`/`load_dcard3`; RESULT at T+17; `player_win_light`=1, `dealer_win_light`=0; `rounds`=1, `player_wins`=1.
- Both draw: `pscore`=4, `dscore`=6, `pcard3`=7, final p=1, d=9 → `load_pcard3` at T+17, `load_dcard3` at T+22, RESULT at T+26; `dealer_win_light`=1, `dealer_wins`=1.
- Dealer stands on `pcard3`: `pscore`=4, `dscore`=6, `pcard3`=5 → `load_pcard3` at T+17, no `load_dcard3`, RESULT at T+22.
- Player stands: `pscore`=6, `dscore`=5, final d=6 → `load_dcard3` at T+17, RESULT at T+21; both lights 1; `ties`=1.
- Reset in D1, then `start` → next cycle: all outputs 0, no strobes. `start` then gives `load_pcard1` one cycle later.
- Saturation: TALLY_W=2 and 5 player wins → `player_wins`=3, `rounds`=3. With the macro undefined → all tallies 0, lights unchanged.
